// File: rtl/spi_result_pkg.sv
// Shared definitions for the SPI result bridge: command bytes, FSM encoding,
// ctrl register bit positions and the READ_STAT reply layout.
package spi_result_pkg;

   localparam logic [7:0] CMD_READ_RESULT = 8'h01;
   localparam logic [7:0] CMD_READ_STAT   = 8'h02;
   localparam logic [7:0] CMD_CLEAR       = 8'h03;
   localparam logic [7:0] CMD_WR_CTRL     = 8'h04;

   localparam int unsigned CTRL_IRQ_EN  = 0;
   localparam int unsigned CTRL_DBG_SEL = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_WRCTRL = 2'd2
   } state_t;

   typedef struct packed {
      logic       overflow;
      logic       full;
      logic       empty;
      logic       rsvd;
      logic [3:0] level;
   } stat_byte_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; reads 0 when empty.
// Pointers carry one extra wrap bit to separate full from empty.
module result_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level_o = wr_ptr - rd_ptr;
   assign rdata_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

   // A push into a full FIFO is accepted only when the head leaves the same cycle
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem[wr_ptr[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/spi_result_bridge.sv
// Buffers measurement frames in a FIFO and serves them byte-wise to an SPI master.
// Optional SPI_RESULT_TIMESTAMP_EN prepends a 16-bit capture timestamp to each frame.
module spi_result_bridge
   import spi_result_pkg::*;
#(
   parameter int unsigned COUNT_W = 16,
   parameter int unsigned STAT_W  = 16,
   parameter int unsigned DEPTH   = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               meas_done_i,
   input  logic [COUNT_W-1:0] count_i,
   input  logic [STAT_W-1:0]  status_i,
   input  logic               rx_dv_i,
   input  logic [7:0]         rx_byte_i,
   input  logic               spi_cs_n_i,
   output logic               tx_dv_o,
   output logic [7:0]         tx_byte_o,
   output logic               irq_o,
   input  logic [31:0]        dbg_ctrl_i,
   output logic [31:0]        dbg_status_o
);

`ifdef SPI_RESULT_TIMESTAMP_EN
   localparam int unsigned TS_W = 16;
`else
   localparam int unsigned TS_W = 0;
`endif
   localparam int unsigned FRAME_W = TS_W + STAT_W + COUNT_W;
   localparam int unsigned NB      = FRAME_W / 8;
   localparam int unsigned BC_W    = $clog2(NB + 1);
   localparam int unsigned AW      = $clog2(DEPTH);

   state_t             state_q, state_d;
   logic [FRAME_W-1:0] push_frame, head, sr_q;
   logic [BC_W-1:0]    bcnt_q;
   logic [7:0]         ctrl_q;
   logic               ovf_q;
   logic [2:0]         cs_q;
   logic               cs_rise;
   logic               fifo_full, fifo_empty;
   logic [AW:0]        fifo_level;
   stat_byte_t         stat_byte;
   logic               tx_dv_c, pop_c, flush_c, ctrl_we_c, sr_ld_c, sr_sh_c;
   logic [7:0]         tx_byte_c;
   logic [31:0]        dbg_c;
   logic [FRAME_W+31:0]        head_ext;
   logic [STAT_W+COUNT_W+31:0] live_ext;
   logic               unused_bits;

`ifdef SPI_RESULT_TIMESTAMP_EN
   logic [15:0] ts_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ts_q <= '0;
      else          ts_q <= ts_q + 16'd1;
   end

   assign push_frame = {ts_q, status_i, count_i};
`else
   assign push_frame = {status_i, count_i};
`endif

   result_fifo #(.WIDTH(FRAME_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (meas_done_i),
      .pop_i   (pop_c),
      .flush_i (flush_c),
      .wdata_i (push_frame),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Two-flop synchroniser plus one history flop; CS deasserting ends any transaction
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cs_q <= 3'b111;
      else          cs_q <= {cs_q[1:0], spi_cs_n_i};
   end
   assign cs_rise = cs_q[1] & ~cs_q[2];

   assign stat_byte = '{overflow: ovf_q, full: fifo_full, empty: fifo_empty, rsvd: 1'b0,
                        level: (fifo_level > (AW+1)'(15)) ? 4'hF : 4'(fifo_level)};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cs_rise) begin
         state_d = ST_IDLE;
      end else if (rx_dv_i) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte_i == CMD_READ_RESULT)  state_d = ST_SEND;
               else if (rx_byte_i == CMD_WR_CTRL) state_d = ST_WRCTRL;
            end
            ST_SEND:   if (bcnt_q == BC_W'(NB)) state_d = ST_IDLE;
            ST_WRCTRL: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_dv_c   = 1'b0;
      tx_byte_c = 8'h00;
      pop_c     = 1'b0;
      flush_c   = 1'b0;
      ctrl_we_c = 1'b0;
      sr_ld_c   = 1'b0;
      sr_sh_c   = 1'b0;
      if (rx_dv_i && !cs_rise) begin
         case (state_q)
            ST_IDLE: begin
               case (rx_byte_i)
                  CMD_READ_RESULT: begin
                     tx_dv_c   = 1'b1;
                     tx_byte_c = head[FRAME_W-1 -: 8];
                     pop_c     = ~fifo_empty;
                     sr_ld_c   = 1'b1;
                  end
                  CMD_READ_STAT: begin
                     tx_dv_c   = 1'b1;
                     tx_byte_c = stat_byte;
                  end
                  CMD_CLEAR:   flush_c = 1'b1;
                  CMD_WR_CTRL: tx_dv_c = 1'b0;
                  default:     tx_dv_c = 1'b1;
               endcase
            end
            ST_SEND: begin
               if (bcnt_q != BC_W'(NB)) begin
                  tx_dv_c   = 1'b1;
                  tx_byte_c = sr_q[FRAME_W-1 -: 8];
                  sr_sh_c   = 1'b1;
               end
            end
            ST_WRCTRL: ctrl_we_c = 1'b1;
            default:   tx_dv_c   = 1'b0;
         endcase
      end
   end

   assign head_ext = {32'd0, head};
   assign live_ext = {32'd0, status_i, count_i};
   assign dbg_c    = (dbg_ctrl_i[31] | ctrl_q[CTRL_DBG_SEL]) ? head_ext[31:0] : live_ext[31:0];

   // Byte 0 leaves on the command itself, so the shift register holds bytes 1..NB-1
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sr_q         <= '0;
         bcnt_q       <= '0;
         ctrl_q       <= 8'h00;
         ovf_q        <= 1'b0;
         tx_dv_o      <= 1'b0;
         tx_byte_o    <= 8'h00;
         irq_o        <= 1'b0;
         dbg_status_o <= 32'd0;
      end else begin
         tx_dv_o <= tx_dv_c;
         if (tx_dv_c) tx_byte_o <= tx_byte_c;
         if (sr_ld_c) begin
            sr_q   <= head << 8;
            bcnt_q <= BC_W'(1);
         end else if (sr_sh_c) begin
            sr_q   <= sr_q << 8;
            bcnt_q <= bcnt_q + BC_W'(1);
         end
         if (ctrl_we_c) ctrl_q <= rx_byte_i;
         if (flush_c)                                  ovf_q <= 1'b0;
         else if (meas_done_i && fifo_full && !pop_c)  ovf_q <= 1'b1;
         irq_o        <= ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | ovf_q);
         dbg_status_o <= dbg_c;
      end
   end

   assign unused_bits = ^{dbg_ctrl_i[30:0], ctrl_q[6:1], head_ext[FRAME_W+31:32],
                          live_ext[STAT_W+COUNT_W+31:32]};

endmodule

// File: tb/tb_spi_result_bridge.sv
// Randomised bench for spi_result_bridge against a queue-based model of the
// command protocol (default build, 16+16-bit frames, depth 8).
module tb_spi_result_bridge;
   import spi_result_pkg::*;

   localparam int DEPTH = 8;

   logic        clk_i, rst_n_i, meas_done_i, rx_dv_i, spi_cs_n_i;
   logic [15:0] count_i, status_i;
   logic [7:0]  rx_byte_i, tx_byte_o;
   logic        tx_dv_o, irq_o;
   logic [31:0] dbg_ctrl_i, dbg_status_o;

   spi_result_bridge dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .meas_done_i(meas_done_i),
      .count_i(count_i), .status_i(status_i), .rx_dv_i(rx_dv_i),
      .rx_byte_i(rx_byte_i), .spi_cs_n_i(spi_cs_n_i), .tx_dv_o(tx_dv_o),
      .tx_byte_o(tx_byte_o), .irq_o(irq_o), .dbg_ctrl_i(dbg_ctrl_i),
      .dbg_status_o(dbg_status_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mq[$];
   bit          m_ovf;
   logic [7:0]  m_ctrl;
   logic [7:0]  byte_q[$];
   logic [7:0]  exp_q[$];

   always @(negedge clk_i) if (tx_dv_o) byte_q.push_back(tx_byte_o);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void m_push(input logic [31:0] f);
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else                    mq.push_back(f);
   endfunction

   function automatic logic [7:0] m_stat();
      int sz = mq.size();
      return {m_ovf, sz == DEPTH, sz == 0, 1'b0, (sz > 15) ? 4'hF : 4'(sz)};
   endfunction

   task automatic cmp_bytes(input string tag);
      check({tag, "_count"}, 32'(byte_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), {24'd0, byte_q[i]}, {24'd0, exp_q[i]});
      byte_q.delete();
      exp_q.delete();
   endtask

   task automatic spi_byte(input logic [7:0] b);
      rx_byte_i = b;
      rx_dv_i   = 1'b1;
      @(posedge clk_i); #1;
      rx_dv_i   = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   task automatic meas(input logic [15:0] c, input logic [15:0] s);
      count_i     = c;
      status_i    = s;
      meas_done_i = 1'b1;
      @(posedge clk_i); #1;
      meas_done_i = 1'b0;
      m_push({s, c});
   endtask

   task automatic do_read(input int n_dummy);
      logic [31:0] f;
      f = 32'd0;
      if (mq.size() != 0) f = mq.pop_front();
      for (int k = 0; k < 4 && k <= n_dummy; k++) exp_q.push_back(f[31-8*k -: 8]);
      spi_byte(CMD_READ_RESULT);
      for (int k = 0; k < n_dummy; k++) spi_byte(8'($urandom));
   endtask

   task automatic do_stat(input string tag);
      exp_q.push_back(m_stat());
      spi_byte(CMD_READ_STAT);
      cmp_bytes(tag);
   endtask

   task automatic ctrl_wr(input logic [7:0] v);
      spi_byte(CMD_WR_CTRL);
      spi_byte(v);
      m_ctrl = v;
   endtask

   task automatic do_clear();
      spi_byte(CMD_CLEAR);
      mq.delete();
      m_ovf = 1'b0;
   endtask

   task automatic cs_pulse();
      spi_cs_n_i = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      spi_cs_n_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
   endtask

   task automatic check_side(input string tag);
      logic sel;
      check({tag, "_irq"}, 32'(irq_o), 32'(m_ctrl[0] & ((mq.size() != 0) | m_ovf)));
      sel = dbg_ctrl_i[31] | m_ctrl[7];
      if (!sel)                check({tag, "_dbg_live"}, dbg_status_o, {status_i, count_i});
      else if (mq.size() != 0) check({tag, "_dbg_head"}, dbg_status_o, mq[0]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      rst_n_i = 1'b0; meas_done_i = 1'b0; rx_dv_i = 1'b0; rx_byte_i = 8'h00;
      spi_cs_n_i = 1'b0; dbg_ctrl_i = 32'd0; count_i = 16'h1234; status_i = 16'hA5C3;
      m_ovf = 1'b0; m_ctrl = 8'h00;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_tx_dv", 32'(tx_dv_o), 32'd0);
      check("rst_tx_byte", 32'(tx_byte_o), 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_dbg", dbg_status_o, 32'd0);
      rst_n_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      do_stat("rst_stat");

      // Single frame read-out, MSB byte first; the 4th dummy produces nothing
      meas(16'h1234, 16'hA5C3);
      exp_q = '{8'hA5, 8'hC3, 8'h12, 8'h34};
      void'(mq.pop_front());
      spi_byte(CMD_READ_RESULT);
      repeat (4) spi_byte(8'hFF);
      cmp_bytes("read1");
      do_stat("read1_empty");

      // Overflow on the ninth push
      ctrl_wr(8'h01);
      for (int i = 0; i < 9; i++) meas(16'($urandom), 16'($urandom));
      do_stat("ovf_stat");
      check("ovf_stat_lit", m_stat(), 8'hC8);
      check_side("ovf");

      // CLEAR: irq drops one cycle after the flush edge
      rx_byte_i = CMD_CLEAR; rx_dv_i = 1'b1;
      @(posedge clk_i); #1;
      rx_dv_i = 1'b0;
      mq.delete(); m_ovf = 1'b0;
      check("clr_irq_lag", 32'(irq_o), 32'd1);
      @(posedge clk_i); #1;
      check("clr_irq_fall", 32'(irq_o), 32'd0);
      do_stat("clr_stat");

      // Push and pop on the same edge while full
      for (int i = 0; i < DEPTH; i++) meas(16'($urandom), 16'($urandom));
      begin
         logic [31:0] f, nf;
         nf = $urandom;
         f  = mq.pop_front();
         mq.push_back(nf);
         exp_q = '{f[31:24], f[23:16], f[15:8], f[7:0]};
         count_i = nf[15:0]; status_i = nf[31:16];
         meas_done_i = 1'b1; rx_byte_i = CMD_READ_RESULT; rx_dv_i = 1'b1;
         @(posedge clk_i); #1;
         meas_done_i = 1'b0; rx_dv_i = 1'b0;
         repeat (2) @(posedge clk_i);
         #1;
         repeat (4) spi_byte(8'h00);
         cmp_bytes("pushpop");
      end
      do_stat("pushpop_stat");

      // Read from an empty FIFO
      do_clear();
      do_read(4);
      cmp_bytes("read_empty");
      do_stat("read_empty_stat");

      // Debug view selection through ctrl
      meas(16'($urandom), 16'($urandom));
      meas(16'($urandom), 16'($urandom));
      ctrl_wr(8'h80);
      check_side("dbg_head");
      ctrl_wr(8'h00);
      count_i = 16'h5A5A; status_i = 16'h0F0F;
      repeat (2) @(posedge clk_i);
      #1;
      check_side("dbg_live");

      // CS rising edge aborts a partial read; popped entry stays gone
      do_clear();
      for (int i = 0; i < 3; i++) meas(16'($urandom), 16'($urandom));
      do_read(1);
      cs_pulse();
      cmp_bytes("cs_abort");
      do_stat("cs_stat");

      // Randomised mix of commands
      for (int it = 0; it < 40; it++) begin
         dbg_ctrl_i = {1'($urandom), 31'($urandom)};
         op = $urandom_range(0, 8);
         case (op)
            0, 1, 2: meas(16'($urandom), 16'($urandom));
            3: begin do_read(4); cmp_bytes("rnd_read"); end
            4: begin do_read($urandom_range(0, 3)); cs_pulse(); cmp_bytes("rnd_part"); end
            5: do_stat("rnd_stat");
            6: ctrl_wr({1'($urandom), 6'($urandom), 1'($urandom)});
            7: do_clear();
            default: begin
               exp_q.push_back(8'h00);
               spi_byte(8'($urandom_range(5, 255)));
               cmp_bytes("rnd_unknown");
            end
         endcase
         repeat (2) @(posedge clk_i);
         #1;
         check_side($sformatf("rnd%0d", it));
      end

      // Asynchronous reset in the middle of a read
      dbg_ctrl_i = 32'd0;
      do_clear();
      ctrl_wr(8'h01);
      meas(16'h1234, 16'hA5C3);
      meas(16'h7777, 16'h8888);
      do_read(0);
      cmp_bytes("pre_rst");
      rst_n_i = 1'b0;
      #1;
      check("mid_rst_tx_dv", 32'(tx_dv_o), 32'd0);
      check("mid_rst_tx_byte", 32'(tx_byte_o), 32'd0);
      check("mid_rst_irq", 32'(irq_o), 32'd0);
      check("mid_rst_dbg", dbg_status_o, 32'd0);
      mq.delete(); m_ovf = 1'b0; m_ctrl = 8'h00;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      byte_q.delete();
      do_stat("post_rst_stat");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
